prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, setting the program RAM address width (16 words).
REQ-002 The block SHALL have parameter DATA_W, default 8, setting the program RAM word width.
REQ-003 Port clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port load_req  input  1  start a program load, sampled in IDLE and HALTED only.
REQ-006 Port load_len  input  ADDR_W  number of words to load, latched with load_req; 0 means 2^ADDR_W.
REQ-007 Port abort  input  1  synchronous return to IDLE from any state.
REQ-008 Port wr_valid  input  1  source presents a program word.
REQ-009 Port wr_data  input  DATA_W  program word.
REQ-010 Port wr_ready  output  1  loader accepts a word this cycle.
REQ-011 Port ram_addr  output  ADDR_W  program RAM write address.
REQ-012 Port ram_data  output  DATA_W  program RAM write data.
REQ-013 Port ram_we  output  1  program RAM write strobe, one cycle per word.
REQ-014 Port hlt  input  1  HLT bit of the instruction controller control word.
REQ-015 Port cpu_enable  output  1  drives the instruction controller enable.
REQ-016 Port cpu_reset  output  1  holds the program counter and instruction controller in reset.
REQ-017 Port busy  output  1  high in LOAD, WRITE and START.
REQ-018 Port done  output  1  high in HALTED.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, WRITE, START, RUN and HALTED, all outputs registered.
REQ-020 IDLE: cpu_reset=1, cpu_enable=0, wr_ready=0, ram_we=0; load_req=1 SHALL latch load_len, clear the address counter to 0 and go to LOAD.
REQ-021 LOAD: wr_ready=1; a transfer occurs only when wr_valid and wr_ready are both 1 in the same cycle.
REQ-022 On a transfer, wr_data SHALL be captured to ram_data and the counter to ram_addr, and the FSM SHALL go to WRITE.
REQ-023 WRITE: ram_we=1 for exactly one cycle, wr_ready=0; the counter SHALL increment modulo 2^ADDR_W.
REQ-024 After WRITE of the last word (words written == latched length), the FSM SHALL go to START; otherwise it SHALL return to LOAD.
REQ-025 Throughput SHALL be one word per 2 cycles; ram_we SHALL rise in the cycle after acceptance.
REQ-026 wr_valid low in LOAD SHALL hold state indefinitely with no timeout.
REQ-027 START: cpu_reset=1, cpu_enable=0 for exactly one cycle, then the FSM SHALL go to RUN.
REQ-028 RUN: cpu_reset=0, cpu_enable=1; load_req SHALL be ignored; hlt=1 SHALL go to HALTED in the next cycle.
REQ-029 HALTED: cpu_enable=0, cpu_reset=0, done=1; load_req=1 SHALL start a new load exactly as from IDLE.
REQ-030 abort SHALL take priority over every other transition, including hlt, load_req and a transfer in the same cycle, and SHALL go to IDLE without issuing ram_we.
REQ-031 With load_len=0, exactly 16 words SHALL be written to addresses 0..15, with no wrap-around write to address 0.
REQ-032 ram_addr and ram_data SHALL hold their last values outside WRITE.

Reset
REQ-033 reset=1 SHALL immediately force IDLE, cpu_reset=1, and cpu_enable, wr_ready, ram_we, busy and done to 0.
REQ-034 reset=1 SHALL immediately clear ram_addr, ram_data and the counter to 0; a reset asserted mid-load SHALL discard the load.
REQ-035 After reset deasserts, no state SHALL be left other than IDLE until load_req is sampled.

Verification
REQ-036 load_len=3, wr_data 0x1E,0x2F,0xE0 back-to-back -> ram_we pulses at addresses 0,1,2 on alternate cycles; START lasts 1 cycle; cpu_enable=1 from the next cycle.
REQ-037 load_len=0 with 16 words -> addresses 0..15 written once each; busy falls after the 16th write.
REQ-038 wr_valid toggling 1,0,0,1 -> only the 2 handshaked words are written, with no extra ram_we.
REQ-039 In RUN, hlt=1 -> done=1 and cpu_enable=0 in the next cycle; load_req=1 then restarts a load at address 0.
REQ-040 abort asserted in the same cycle as a transfer -> IDLE, no ram_we, cpu_reset=1.
REQ-041 reset asserted asynchronously mid-WRITE -> ram_we=0 and IDLE outputs without waiting for clk.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a program into the instruction RAM, then starts the CPU.
//
// A load is started with load_req, sampled in IDLE or HALTED. load_len gives
// the number of words; 0 means a full RAM of 2^ADDR_W words. Each word is
// accepted with a valid/ready handshake and written one cycle later. After the
// last write, the CPU is held in reset for one more cycle (START) and is then
// enabled (RUN). When the CPU raises hlt, the loader parks in HALTED. From
// HALTED a new load can be started.
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   reset       asynchronous, active-high reset
//   load_req    start a program load (IDLE / HALTED only)
//   load_len    word count for the load, latched with load_req (0 = 2^ADDR_W)
//   abort       synchronous return to IDLE from any state, highest priority
//   wr_valid    source presents a program word
//   wr_data     program word
//   wr_ready    loader accepts a word this cycle
//   ram_addr    program RAM write address (holds outside WRITE)
//   ram_data    program RAM write data (holds outside WRITE)
//   ram_we      program RAM write strobe, one cycle per word
//   hlt         HLT bit from the instruction controller
//   cpu_enable  instruction controller enable
//   cpu_reset   holds PC and instruction controller in reset
//   busy        high while loading or starting (LOAD, WRITE, START)
//   done        high in HALTED
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic              hlt,
    output logic              cpu_enable,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        START,
        RUN,
        HALTED
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;     // address of the next word to be accepted
    logic [ADDR_W-1:0] last_q;  // address of the final word of this load
    logic [5:0]        ctl;     // registered control outputs, see ctl_for()

    // Output decode for a given state. Outputs are loaded together with the
    // state register, so they always describe the state currently held.
    // Bit order: {cpu_reset, cpu_enable, wr_ready, ram_we, busy, done}
    function automatic logic [5:0] ctl_for(input state_t s);
        logic [5:0] c;
        case (s)
            IDLE:    c = 6'b100000;
            LOAD:    c = 6'b101010;
            WRITE:   c = 6'b100110;
            START:   c = 6'b100010;
            RUN:     c = 6'b010000;
            HALTED:  c = 6'b000001;
            default: c = 6'b100000;
        endcase
        return c;
    endfunction

    assign {cpu_reset, cpu_enable, wr_ready, ram_we, busy, done} = ctl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ctl      <= ctl_for(IDLE);
            cnt      <= '0;
            last_q   <= '0;
            ram_addr <= '0;
            ram_data <= '0;
        end else if (abort) begin
            // Abort wins over load_req, hlt and a handshake in the same cycle;
            // nothing is captured, so no write strobe follows.
            state <= IDLE;
            ctl   <= ctl_for(IDLE);
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (load_req) begin
                        // Storing len-1 makes load_len=0 land on the top
                        // address, so a full-RAM load ends at 2^ADDR_W-1 and
                        // never wraps back to address 0.
                        last_q <= load_len - ADDR_W'(1);
                        cnt    <= '0;
                        state  <= LOAD;
                        ctl    <= ctl_for(LOAD);
                    end
                end
                LOAD: begin
                    if (wr_valid && wr_ready) begin
                        ram_data <= wr_data;
                        ram_addr <= cnt;
                        state    <= WRITE;
                        ctl      <= ctl_for(WRITE);
                    end
                end
                WRITE: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == last_q) begin
                        state <= START;
                        ctl   <= ctl_for(START);
                    end else begin
                        state <= LOAD;
                        ctl   <= ctl_for(LOAD);
                    end
                end
                START: begin
                    state <= RUN;
                    ctl   <= ctl_for(RUN);
                end
                RUN: begin
                    if (hlt) begin
                        state <= HALTED;
                        ctl   <= ctl_for(HALTED);
                    end
                end
                default: begin
                    state <= IDLE;
                    ctl   <= ctl_for(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader with a word-count based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_prog_loader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_WRITE = 2;
    localparam int M_START = 3;
    localparam int M_RUN   = 4;
    localparam int M_HALT  = 5;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              load_req = 1'b0;
    logic [ADDR_W-1:0] load_len = '0;
    logic              abort    = 1'b0;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              hlt      = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_we;
    logic              cpu_enable;
    logic              cpu_reset;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    prog_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .load_len  (load_len),
        .abort     (abort),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .hlt       (hlt),
        .cpu_enable(cpu_enable),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks words remaining and the next address as plain
    // integers; outputs are derived from the current phase of the protocol.
    int                m_mode      = M_IDLE;
    int                m_left      = 0;
    int                m_next_addr = 0;
    logic [ADDR_W-1:0] m_addr      = '0;
    logic [DATA_W-1:0] m_data      = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode      <= M_IDLE;
            m_left      <= 0;
            m_next_addr <= 0;
            m_addr      <= '0;
            m_data      <= '0;
        end else if (abort) begin
            m_mode <= M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE, M_HALT: if (load_req) begin
                    m_left      <= (load_len == 0) ? DEPTH : int'(load_len);
                    m_next_addr <= 0;
                    m_mode      <= M_LOAD;
                end
                M_LOAD: if (wr_valid) begin
                    m_addr <= m_next_addr[ADDR_W-1:0];
                    m_data <= wr_data;
                    m_mode <= M_WRITE;
                end
                M_WRITE: begin
                    m_left      <= m_left - 1;
                    m_next_addr <= m_next_addr + 1;
                    m_mode      <= (m_left == 1) ? M_START : M_LOAD;
                end
                M_START: m_mode <= M_RUN;
                M_RUN:   if (hlt) m_mode <= M_HALT;
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // Compare process plus a log of every write strobe and every rise of cpu_enable.
    bit                chk_on = 1'b0;
    int                cyc    = 0;
    logic              prev_we = 1'b0;
    logic              prev_en = 1'b0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [DATA_W-1:0] log_data[$];
    int                log_cyc[$];
    int                en_cyc[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (chk_on) begin
            check("cpu_reset",  cpu_reset,  (m_mode == M_IDLE || m_mode == M_LOAD ||
                                             m_mode == M_WRITE || m_mode == M_START));
            check("cpu_enable", cpu_enable, (m_mode == M_RUN));
            check("wr_ready",   wr_ready,   (m_mode == M_LOAD));
            check("ram_we",     ram_we,     (m_mode == M_WRITE));
            check("busy",       busy,       (m_mode == M_LOAD || m_mode == M_WRITE ||
                                             m_mode == M_START));
            check("done",       done,       (m_mode == M_HALT));
            check("ram_addr",   ram_addr,   m_addr);
            check("ram_data",   ram_data,   m_data);
            if (ram_we === 1'b1) begin
                check("ram_we_back_to_back", prev_we, 1'b0);
                log_addr.push_back(ram_addr);
                log_data.push_back(ram_data);
                log_cyc.push_back(cyc);
            end
            if (cpu_enable === 1'b1 && prev_en !== 1'b1) en_cyc.push_back(cyc);
        end
        prev_we = ram_we;
        prev_en = cpu_enable;
    end

    // Stimulus helpers; all are entered and left on a falling edge.
    task automatic start_load(input logic [ADDR_W-1:0] len);
        load_req = 1'b1;
        load_len = len;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input int gap);
        int n = 0;
        wr_data  = d;
        wr_valid = 1'b1;
        while (wr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("handshake_timeout", wr_ready, 1'b1);
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_enable();
        int n = 0;
        while (cpu_enable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("enable_timeout", cpu_enable, 1'b1);
    endtask

    task automatic halt_cpu();
        hlt = 1'b1;
        @(negedge clk);
        hlt = 1'b0;
        check("halt_done", done, 1'b1);
        check("halt_cpu_enable", cpu_enable, 1'b0);
        check("halt_cpu_reset", cpu_reset, 1'b0);
    endtask

    logic [DATA_W-1:0] t1_data[3] = '{8'h1E, 8'h2F, 8'hE0};

    initial begin
        int base;
        int ebase;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cpu_reset",  cpu_reset,  1'b1);
        check("rst_cpu_enable", cpu_enable, 1'b0);
        check("rst_wr_ready",   wr_ready,   1'b0);
        check("rst_ram_we",     ram_we,     1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_done",       done,       1'b0);
        check("rst_ram_addr",   ram_addr,   '0);
        check("rst_ram_data",   ram_data,   '0);
        reset  = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Three back-to-back words
        base  = log_addr.size();
        ebase = en_cyc.size();
        start_load(4'd3);
        for (int i = 0; i < 3; i++) send_word(t1_data[i], 0);
        wait_enable();
        check("t1_count", log_addr.size() - base, 3);
        if (log_addr.size() - base == 3 && en_cyc.size() > ebase) begin
            for (int i = 0; i < 3; i++) begin
                check("t1_addr", log_addr[base+i], i);
                check("t1_data", log_data[base+i], t1_data[i]);
            end
            check("t1_spacing_a", log_cyc[base+1] - log_cyc[base], 2);
            check("t1_spacing_b", log_cyc[base+2] - log_cyc[base+1], 2);
            check("t1_enable_latency", en_cyc[ebase] - log_cyc[base+2], 2);
        end

        // load_req ignored while running, then halt
        start_load(4'd5);
        check("run_ignores_load_enable", cpu_enable, 1'b1);
        check("run_ignores_load_busy", busy, 1'b0);
        halt_cpu();

        // Restart from HALTED with a gappy source: valid 1,0,0,1
        base = log_addr.size();
        start_load(4'd2);
        check("restart_busy", busy, 1'b1);
        send_word(8'hA5, 2);
        send_word(8'h5A, 0);
        wait_enable();
        check("t2_count", log_addr.size() - base, 2);
        if (log_addr.size() - base == 2) begin
            check("t2_addr0", log_addr[base],   0);
            check("t2_data0", log_data[base],   8'hA5);
            check("t2_addr1", log_addr[base+1], 1);
            check("t2_data1", log_data[base+1], 8'h5A);
        end
        halt_cpu();

        // Full-RAM load with load_len = 0
        base  = log_addr.size();
        ebase = en_cyc.size();
        start_load(4'd0);
        for (int i = 0; i < DEPTH; i++) send_word(DATA_W'(8'h80 + i), 0);
        wait_enable();
        check("t3_count", log_addr.size() - base, DEPTH);
        if (log_addr.size() - base == DEPTH && en_cyc.size() > ebase) begin
            for (int i = 0; i < DEPTH; i++) begin
                check("t3_addr", log_addr[base+i], i);
                check("t3_data", log_data[base+i], 8'h80 + i);
            end
            check("t3_enable_latency", en_cyc[ebase] - log_cyc[base+DEPTH-1], 2);
        end
        check("t3_hold_addr", ram_addr, 4'hF);
        check("t3_hold_data", ram_data, 8'h8F);
        halt_cpu();

        // Stall indefinitely in LOAD, then abort together with a handshake
        base = log_addr.size();
        start_load(4'd4);
        repeat (20) @(negedge clk);
        check("stall_wr_ready", wr_ready, 1'b1);
        check("stall_busy", busy, 1'b1);
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        wr_valid = 1'b0;
        check("abort_ram_we", ram_we, 1'b0);
        check("abort_cpu_reset", cpu_reset, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_wr_ready", wr_ready, 1'b0);
        check("abort_hold_addr", ram_addr, 4'hF);
        check("abort_hold_data", ram_data, 8'h8F);
        @(negedge clk);
        check("abort_no_write", log_addr.size() - base, 0);

        // Abort beats hlt while running
        start_load(4'd1);
        send_word(8'h11, 0);
        wait_enable();
        hlt   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        hlt   = 1'b0;
        abort = 1'b0;
        check("abort_hlt_done", done, 1'b0);
        check("abort_hlt_cpu_reset", cpu_reset, 1'b1);

        // Asynchronous reset in the middle of WRITE
        start_load(4'd2);
        wr_valid = 1'b1;
        wr_data  = 8'hC3;
        @(negedge clk);
        wr_valid = 1'b0;
        check("pre_reset_ram_we", ram_we, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_ram_we",     ram_we,     1'b0);
        check("async_cpu_reset",  cpu_reset,  1'b1);
        check("async_cpu_enable", cpu_enable, 1'b0);
        check("async_wr_ready",   wr_ready,   1'b0);
        check("async_busy",       busy,       1'b0);
        check("async_done",       done,       1'b0);
        check("async_ram_addr",   ram_addr,   '0);
        check("async_ram_data",   ram_data,   '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_idle_busy", busy, 1'b0);

        // Recovery: a fresh one-word load starts at address 0
        base = log_addr.size();
        start_load(4'd1);
        send_word(8'h3C, 0);
        wait_enable();
        check("t4_count", log_addr.size() - base, 1);
        if (log_addr.size() - base == 1) begin
            check("t4_addr", log_addr[base], 0);
            check("t4_data", log_data[base], 8'h3C);
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
